// File: rtl/cube_pkg.sv
// -----------------------------------------------------------------------------
// cube_pkg
// Shared definitions for the iterative cube unit:
//   - cube_state_e : FSM encoding (IDLE / SQ / CU / DONE)
//   - CUBE_LAT()   : cycles from the accept edge to the result edge
//   - handshake constants shared with the cube-root unit's sequencer
// -----------------------------------------------------------------------------
package cube_pkg;

    // FSM encoding for the two-pass cube sequencer
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SQ   = 2'd1,
        ST_CU   = 2'd2,
        ST_DONE = 2'd3
    } cube_state_e;

    // start_c level that requests a computation
    localparam logic START_ACTIVE      = 1'b1;
    // Arming flag value after reset: a start seen on the first edge after
    // reset release is accepted
    localparam logic ARMED_AFTER_RESET = 1'b1;

    // Two products, each one load edge plus w shift-add edges
    function automatic int unsigned CUBE_LAT(input int unsigned w);
        return 32'd2 * (w + 32'd1);
    endfunction

endpackage

// File: rtl/cube_if.sv
// -----------------------------------------------------------------------------
// cube_if
// Request/response bundle of the cube unit (same shape as the cube-root unit).
//   start_c : request level (host -> unit)
//   x       : operand, WIDTH bits (host -> unit)
//   result  : x^3, 3*WIDTH bits (unit -> host)
//   busy    : computation in flight (unit -> host)
// Modports: master = host side, slave = unit side.
// -----------------------------------------------------------------------------
interface cube_if #(
    parameter int WIDTH = 8
);
    import cube_pkg::*;

    logic                 start_c;
    logic [WIDTH-1:0]     x;
    logic [3*WIDTH-1:0]   result;
    logic                 busy;

    modport master (
        output start_c,
        output x,
        input  result,
        input  busy
    );

    modport slave (
        input  start_c,
        input  x,
        output result,
        output busy
    );

endinterface

// File: rtl/cube_calc_mul.sv
// -----------------------------------------------------------------------------
// shift_add_mul
// Sequential shift-add multiplier, LSB of the multiplier operand first.
//   clk_c : clock (posedge)
//   rst_c : synchronous active-high reset, clears all state
//   load  : capture a/b and clear the accumulator
//   a     : multiplicand, A_W bits
//   b     : multiplier operand, B_W bits
//   p     : product, P_W bits (valid while done is high)
//   done  : high once B_W iterations completed after load, until next load
// -----------------------------------------------------------------------------
module shift_add_mul
    import cube_pkg::*;
#(
    parameter int A_W = 16,
    parameter int B_W = 8,
    parameter int P_W = 24
) (
    input  logic           clk_c,
    input  logic           rst_c,
    input  logic           load,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [P_W-1:0] p,
    output logic           done
);

    localparam int CNT_W = $clog2(B_W + 1);

    logic [P_W-1:0]   r_mcand;
    logic [B_W-1:0]   r_mplier;
    logic [P_W-1:0]   r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    // Load, then one conditional add plus shift per edge until B_W bits used
    always_ff @(posedge clk_c) begin
        if (rst_c) begin
            r_mcand  <= {P_W{1'b0}};
            r_mplier <= {B_W{1'b0}};
            r_acc    <= {P_W{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_done   <= 1'b0;
        end else if (load) begin
            r_mcand  <= P_W'(a);
            r_mplier <= b;
            r_acc    <= {P_W{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_done   <= 1'b0;
        end else if (!r_done) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= {r_mcand[P_W-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[B_W-1:1]};
            r_cnt    <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(B_W - 1)) begin
                r_done <= 1'b1;
            end
        end
    end

    assign p    = r_acc;
    assign done = r_done;

endmodule

// File: rtl/cube_calc.sv
// -----------------------------------------------------------------------------
// cube_calc
// Iterative unsigned cube: result = x^3, computed by reusing one shift-add
// multiplier twice (x*x, then sq*x). Fixed latency CUBE_LAT(WIDTH) edges from
// the accept edge to the edge that writes result and drops busy.
//   clk_c : clock (posedge)
//   rst_c : synchronous active-high reset, aborts any computation
//   bus   : cube_if slave (start_c, x in; result, busy out, both registered)
// Handshake: a start is accepted when armed and not busy; the unit disarms on
// accept and re-arms on any edge that sees start_c low, so a held start gives
// exactly one computation.
// -----------------------------------------------------------------------------
module cube_calc
    import cube_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic  clk_c,
    input  logic  rst_c,
    cube_if.slave bus
);

    cube_state_e          r_state;
    cube_state_e          w_next_state;
    logic                 r_armed;
    logic                 r_busy;
    logic [3*WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]     r_x;

    logic                 w_accept;
    logic                 w_load;
    logic [2*WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]     w_b;
    logic [3*WIDTH-1:0]   w_p;
    logic                 w_done;

    // busy is low only in IDLE or DONE, so an accept can also leave DONE
    assign w_accept = r_armed && !r_busy && (bus.start_c == START_ACTIVE);

    // Next state and multiplier load/operand selection
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_a          = {{WIDTH{1'b0}}, bus.x};
        w_b          = bus.x;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                // The accept edge doubles as the load edge of x*x, taking
                // the operand straight from the port
                if (w_accept) begin
                    w_next_state = ST_SQ;
                    w_load       = 1'b1;
                    w_a          = {{WIDTH{1'b0}}, bus.x};
                    w_b          = bus.x;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SQ: begin
                // Square is ready: reload with sq * x_r
                if (w_done) begin
                    w_next_state = ST_CU;
                    w_load       = 1'b1;
                    w_a          = w_p[2*WIDTH-1:0];
                    w_b          = r_x;
                end else begin
                    w_next_state = ST_SQ;
                end
            end
            ST_CU: begin
                if (w_done) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_CU;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, arming flag, operand capture and registered outputs
    always_ff @(posedge clk_c) begin
        if (rst_c) begin
            r_state  <= ST_IDLE;
            r_armed  <= ARMED_AFTER_RESET;
            r_busy   <= 1'b0;
            r_result <= {(3*WIDTH){1'b0}};
            r_x      <= {WIDTH{1'b0}};
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_busy   <= 1'b1;
                r_result <= {(3*WIDTH){1'b0}};
                r_x      <= bus.x;
                r_armed  <= 1'b0;
            end else begin
                // Write-back on the edge that moves CU -> DONE
                if ((r_state == ST_CU) && w_done) begin
                    r_result <= w_p;
                    r_busy   <= 1'b0;
                end
                if (!r_armed && (bus.start_c != START_ACTIVE)) begin
                    r_armed <= 1'b1;
                end
            end
        end
    end

    shift_add_mul #(
        .A_W (2*WIDTH),
        .B_W (WIDTH),
        .P_W (3*WIDTH)
    ) u_mul (
        .clk_c (clk_c),
        .rst_c (rst_c),
        .load  (w_load),
        .a     (w_a),
        .b     (w_b),
        .p     (w_p),
        .done  (w_done)
    );

    assign bus.result = r_result;
    assign bus.busy   = r_busy;

endmodule

// File: tb/tb_cube_calc.sv
// -----------------------------------------------------------------------------
// tb_cube_calc
// Scoreboard bench for cube_calc: the driver pushes x^3 (plain arithmetic)
// when it issues a request; a monitor pops and compares whenever busy falls,
// and also checks the busy pulse width against CUBE_LAT.
// -----------------------------------------------------------------------------
module tb_cube_calc;
    import cube_pkg::*;

    localparam int W   = 8;
    localparam int LAT = int'(CUBE_LAT(W));

    logic clk_c = 1'b0;
    logic rst_c = 1'b1;

    cube_if #(.WIDTH(W)) bus ();

    cube_calc #(.WIDTH(W)) dut (
        .clk_c (clk_c),
        .rst_c (rst_c),
        .bus   (bus)
    );

    always #5 clk_c = ~clk_c;

    longint exp_q[$];
    int     n_vec = 0;
    int     n_err = 0;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_c);
    endtask

    task automatic check(input string name, input longint got, input longint want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (bus.busy && t < 4 * LAT) begin
            cyc(1);
            t++;
        end
        n_vec++;
        if (bus.busy) begin
            n_err++;
            $display("FAIL %s_timeout: busy still %0d after %0d cycles, expected 0", name, bus.busy, t);
        end
    endtask

    task automatic do_reset();
        rst_c       = 1'b1;
        bus.start_c = 1'b0;
        cyc(2);
        check("reset_busy", longint'(bus.busy), 64'd0);
        check("reset_result", longint'(bus.result), 64'd0);
        rst_c = 1'b0;
    endtask

    // One request: start pulse for a single edge, then wait for completion
    task automatic run(input int xv);
        bus.x       = W'(xv);
        bus.start_c = 1'b1;
        exp_q.push_back(longint'(xv) * longint'(xv) * longint'(xv));
        cyc(1);
        bus.start_c = 1'b0;
        check("busy_after_accept", longint'(bus.busy), 64'd1);
        wait_idle("run");
    endtask

    // Monitor: on each busy falling edge compare result and busy width
    initial begin
        bit     prev_busy;
        int     bw;
        longint e;
        prev_busy = 1'b0;
        bw        = 0;
        forever begin
            @(negedge clk_c);
            if (rst_c) begin
                prev_busy = 1'b0;
                bw        = 0;
            end else begin
                if (bus.busy) begin
                    bw++;
                end else if (prev_busy) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_result: got %0d with no pending request, expected none", bus.result);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", longint'(bus.result), e);
                    end
                    check("busy_width", longint'(bw), longint'(LAT));
                    bw = 0;
                end
                prev_busy = bus.busy;
            end
        end
    end

    initial begin
        bus.start_c = 1'b0;
        bus.x       = '0;
        do_reset();

        // Basic and extremes
        run(6);
        run(0);
        run(255);
        run(1);

        // Held start: exactly one computation
        bus.x       = W'(3);
        bus.start_c = 1'b1;
        exp_q.push_back(64'd27);
        cyc(50);
        check("held_busy_low", longint'(bus.busy), 64'd0);
        check("held_result", longint'(bus.result), 64'd27);
        bus.start_c = 1'b0;
        cyc(1);
        run(4);

        // Operand change and start drop mid-operation
        bus.x       = W'(5);
        bus.start_c = 1'b1;
        exp_q.push_back(64'd125);
        cyc(4);
        bus.x       = W'(200);
        bus.start_c = 1'b0;
        check("midop_busy", longint'(bus.busy), 64'd1);
        wait_idle("midop");
        check("midop_result", longint'(bus.result), 64'd125);

        // Reset mid-operation aborts with no result
        bus.x       = W'(9);
        bus.start_c = 1'b1;
        cyc(1);
        bus.start_c = 1'b0;
        cyc(6);
        rst_c = 1'b1;
        cyc(1);
        check("abort_busy", longint'(bus.busy), 64'd0);
        check("abort_result", longint'(bus.result), 64'd0);
        rst_c = 1'b0;
        run(2);

        // Exhaustive sweep, back-to-back (accept right after completion)
        for (int i = 0; i < 256; i++) begin
            run(i);
        end

        // Random operands with random gaps
        for (int k = 0; k < 60; k++) begin
            cyc(int'($urandom_range(0, 3)));
            run(int'($urandom_range(0, 255)));
        end

        cyc(3);
        check("queue_drained", longint'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cube_calc.md
Name: cube_calc

Overview:
- Iterative integer cube unit: result = x^3 for an unsigned WIDTH-bit operand.
- Forward (power) counterpart to the team's iterative cube-root unit; uses the same start/busy request handshake so the same host sequencer can drive either block.
- Used to check cube-root outputs in hardware: cube(root(x)) <= x < cube(root(x)+1).
- Built from one sequential shift-add multiplier reused twice, no DSP multiplier.

Parameters:
- WIDTH, 8, operand width; result width is 3*WIDTH.
- LAT, 2*(WIDTH+1) (=18), derived localparam: cycles from accept edge to result; not overridable.

Ports:
- clk_c  in  1  clock, all logic on posedge.
- rst_c  in  1  synchronous active-high reset.
- start_c  in  1  request; level, sampled each edge.
- x  in  WIDTH  operand; captured only on the accept edge.
- result  out  3*WIDTH  x^3 (registered).
- busy  out  1  high while a computation is in flight (registered).

Behaviour:
- Reset (rst_c=1 at an edge, overrides everything): busy=0, result=0, state=IDLE, armed=1, multiplier cleared. A computation in flight is aborted with no partial result.
- Accept condition: rst_c=0, armed=1, busy=0, start_c=1 at edge E0.
  - On E0: busy<=1, result<=0, x latched into x_r, armed<=0, state<=SQ.
- Re-arm: armed<=1 on any edge where armed=0 and start_c=0.
  - Holding start_c high therefore gives exactly one computation.
  - start_c must be seen low for >=1 edge before the next accept.
  - If start_c is high on the first edge after reset release, it is accepted.
- After accept, start_c and x are ignored; deasserting start_c mid-operation does not stall or abort the computation.
- Start arriving while busy=1: ignored, not queued.
- FSM states:
  - IDLE: wait for the accept condition.
  - SQ: multiplier computes x_r*x_r (2*WIDTH bits).
  - CU: multiplier computes sq*x_r (3*WIDTH bits).
  - DONE: single-cycle write-back, then IDLE.
- Multiplier: one load cycle plus WIDTH shift-add iterations per product (LSB of the multiplier operand first).
  - Each iteration: if the operand bit is 1, acc += shifted multiplicand; shift.
  - acc is 3*WIDTH bits wide, so no overflow: max 255^3 = 16581375 = 0xFD02FF fits 24 bits.
- Latency is fixed and data-independent:
  - busy=1 observed after edges E0..E(LAT-1).
  - At edge E(LAT), result<=x_r^3 and busy<=0 in the same edge.
  - result and busy=0 are visible from that edge on.
- result holds its value until the next reset or the next accept (which clears it to 0).
- x=0 and x=1 take the full LAT cycles; no early exit.

Decomposition:
- Shared package cube_pkg:
  - state encoding IDLE/SQ/CU/DONE (2-bit);
  - CUBE_LAT function of WIDTH, reused by the bench;
  - the handshake rule documented as constants.
- One sub-module: shift_add_mul.
  - Parameterised A_W=2*WIDTH, B_W=WIDTH, P_W=3*WIDTH.
  - Ports: clk_c, rst_c, load, a, b, p, done.
  - done is high once WIDTH iterations have completed after load; it stays high until the next load.
- cube_calc contains the FSM, arming flag, x_r/sq registers, and sequences two loads of shift_add_mul.

Test Plan:
- Basic: reset, x=6, start_c high 1 cycle -> busy high exactly 18 cycles; then result=216, busy=0.
- Extremes: x=0 -> result=0 after 18 cycles; x=255 -> result=16581375 (0xFD02FF); x=1 -> result=1.
- Held start: x=3, start_c held high for 50 cycles -> one computation, result=27, busy stays 0 afterwards. Drop start 1 cycle then raise with x=4 -> result=64.
- Operand change mid-op: x=5 accepted, x driven to 200 and start_c dropped at cycle 4 -> result=125 at cycle 18.
- Reset mid-op: x=9 accepted, rst_c=1 at cycle 7 -> next edge busy=0, result=0. Start after reset with x=2 -> result=8 after 18 cycles.
- Exhaustive sweep 0..255 with start pulse and re-arm -> every result equals x^3; busy width is always 18.
